// File: rtl/axiregbank_pkg.sv
// Shared constants and helpers for the AXI4-lite register bank.
package axiregbank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/axiregbank.sv
// AXI4-lite slave exposing NUM_REGS 32-bit read/write registers with
// independent AW/W acceptance, byte strobes and per-register write pulses.
module axiregbank
   import axiregbank_pkg::*;
#(
   parameter int          NUM_REGS  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     axi_awvalid,
   output logic                     axi_awready,
   input  logic [31:0]              axi_awaddr,
   input  logic [2:0]               axi_awprot,
   input  logic                     axi_wvalid,
   output logic                     axi_wready,
   input  logic [31:0]              axi_wdata,
   input  logic [3:0]               axi_wstrb,
   output logic                     axi_bvalid,
   input  logic                     axi_bready,
   output logic [1:0]               axi_bresp,
   input  logic                     axi_arvalid,
   output logic                     axi_arready,
   input  logic [31:0]              axi_araddr,
   input  logic [2:0]               axi_arprot,
   output logic                     axi_rvalid,
   input  logic                     axi_rready,
   output logic [31:0]              axi_rdata,
   output logic [1:0]               axi_rresp,
   output logic [32*NUM_REGS-1:0]   regs_out,
   output logic [NUM_REGS-1:0]      wr_pulse
);

   localparam int          CLOG    = clog2(NUM_REGS);
   // Index field is at least one bit wide so NUM_REGS == 1 still elaborates.
   localparam int          IW      = (CLOG < 1) ? 1 : CLOG;
   localparam logic [31:0] SPAN    = 32'(4) << CLOG;
   localparam logic [31:0] MASK    = SPAN - 32'd1;
   localparam logic [31:0] NREGS32 = 32'(NUM_REGS);

   function automatic logic [IW-1:0] addr_idx(input logic [31:0] addr);
      return addr[2 +: IW];
   endfunction

   function automatic logic addr_hit(input logic [31:0] addr);
      return ((addr & ~MASK) == BASE_ADDR) && (32'(addr_idx(addr)) < NREGS32);
   endfunction

   logic [31:0]          r_regs [NUM_REGS];
   logic                 r_aw_held;
   logic [31:0]          r_aw_addr;
   logic                 r_w_held;
   logic [31:0]          r_w_data;
   logic [3:0]           r_w_strb;
   logic                 r_bvalid;
   logic [1:0]           r_bresp;
   logic                 r_rvalid;
   logic [31:0]          r_rdata;
   logic [1:0]           r_rresp;
   logic [NUM_REGS-1:0]  r_wr_pulse;

   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_ar_hs;
   logic                 w_commit;
   logic [31:0]          w_wr_addr;
   logic [31:0]          w_wr_data;
   logic [3:0]           w_wr_strb;
   logic                 w_wr_hit;
   logic [IW-1:0]        w_wr_idx;
   logic                 w_rd_hit;
   logic [IW-1:0]        w_rd_idx;
   logic                 w_unused;

   assign axi_awready = !r_aw_held && !r_bvalid;
   assign axi_wready  = !r_w_held && !r_bvalid;
   assign axi_arready = !r_rvalid;

   assign w_aw_hs  = axi_awvalid && axi_awready;
   assign w_w_hs   = axi_wvalid && axi_wready;
   assign w_ar_hs  = axi_arvalid && axi_arready;
   // Each half is available either from its holding register or from a live handshake.
   assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;

   assign w_wr_addr = r_aw_held ? r_aw_addr : axi_awaddr;
   assign w_wr_data = r_w_held  ? r_w_data  : axi_wdata;
   assign w_wr_strb = r_w_held  ? r_w_strb  : axi_wstrb;
   assign w_wr_hit  = addr_hit(w_wr_addr);
   assign w_wr_idx  = addr_idx(w_wr_addr);
   assign w_rd_hit  = addr_hit(axi_araddr);
   assign w_rd_idx  = addr_idx(axi_araddr);

   assign w_unused = ^{axi_awprot, axi_arprot};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_aw_held  <= 1'b0;
         r_aw_addr  <= '0;
         r_w_held   <= 1'b0;
         r_w_data   <= '0;
         r_w_strb   <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_wr_pulse <= '0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
            if (w_wr_hit) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (w_wr_idx == IW'(i)) begin
                     for (int b = 0; b < 4; b++) begin
                        if (w_wr_strb[b]) r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
                     end
                     if (|w_wr_strb) r_wr_pulse[i] <= 1'b1;
                  end
               end
            end
         end else begin
            if (w_aw_hs) begin
               r_aw_held <= 1'b1;
               r_aw_addr <= axi_awaddr;
            end
            if (w_w_hs) begin
               r_w_held <= 1'b1;
               r_w_data <= axi_wdata;
               r_w_strb <= axi_wstrb;
            end
            if (r_bvalid && axi_bready) r_bvalid <= 1'b0;
         end
      end
   end

   // Read channel; register values are sampled before any same-edge write lands.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
         r_rdata  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_hit && w_rd_idx == IW'(i)) r_rdata <= r_regs[i];
         end
      end else if (r_rvalid && axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_out[32*g +: 32] = r_regs[g];
   end

   assign axi_bvalid = r_bvalid;
   assign axi_bresp  = r_bresp;
   assign axi_rvalid = r_rvalid;
   assign axi_rdata  = r_rdata;
   assign axi_rresp  = r_rresp;
   assign wr_pulse   = r_wr_pulse;

endmodule

// File: tb/tb_axiregbank.sv
// Directed bench for axiregbank: scoreboarded write/read responses and register model.
module tb_axiregbank;

   localparam int          NR   = 16;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic                 clk = 1'b0;
   logic                 resetn = 1'b0;
   logic                 axi_awvalid = 1'b0, axi_awready;
   logic [31:0]          axi_awaddr = '0;
   logic [2:0]           axi_awprot = '0;
   logic                 axi_wvalid = 1'b0, axi_wready;
   logic [31:0]          axi_wdata = '0;
   logic [3:0]           axi_wstrb = '0;
   logic                 axi_bvalid, axi_bready = 1'b1;
   logic [1:0]           axi_bresp;
   logic                 axi_arvalid = 1'b0, axi_arready;
   logic [31:0]          axi_araddr = '0;
   logic [2:0]           axi_arprot = '0;
   logic                 axi_rvalid, axi_rready = 1'b1;
   logic [31:0]          axi_rdata;
   logic [1:0]           axi_rresp;
   logic [32*NR-1:0]     regs_out;
   logic [NR-1:0]        wr_pulse;

   int                   n_checks = 0;
   int                   n_fail = 0;
   logic [31:0]          model [NR];
   logic [33:0]          exp_q[$];   // {rresp, rdata}
   logic [1:0]           exp_b_q[$];

   axiregbank #(.NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
      .clk(clk), .resetn(resetn),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
      .axi_awprot(axi_awprot),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
      .axi_arprot(axi_arprot),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
      .axi_rresp(axi_rresp),
      .regs_out(regs_out), .wr_pulse(wr_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag);
      for (int i = 0; i < NR; i++) chk($sformatf("%s_reg%0d", tag, i), regs_out[32*i +: 32], model[i]);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Pops the expected write response and checks it against the live B channel.
   task automatic chk_b(input string tag);
      logic [1:0] e;
      chk({tag, "_bvalid"}, 32'(axi_bvalid), 32'd1);
      if (exp_b_q.size() == 0) begin
         chk({tag, "_bq_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_b_q.pop_front();
         chk({tag, "_bresp"}, 32'(axi_bresp), 32'(e));
      end
   endtask

   // Called at a negedge; returns at the negedge following the commit edge.
   task automatic do_write(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
      logic aw_done, w_done, aw_fire, w_fire;
      int idx;
      axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
      axi_awvalid = 1'b1; axi_wvalid = 1'b1;
      aw_done = 1'b0; w_done = 1'b0;
      for (int k = 0; k < 50 && !(aw_done && w_done); k++) begin
         aw_fire = axi_awvalid && axi_awready;
         w_fire  = axi_wvalid && axi_wready;
         @(negedge clk);
         if (aw_fire) begin aw_done = 1'b1; axi_awvalid = 1'b0; end
         if (w_fire)  begin w_done = 1'b1;  axi_wvalid = 1'b0; end
      end
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      chk({tag, "_wr_accept"}, 32'(aw_done && w_done), 32'd1);
      idx = int'((addr - BASE) >> 2);
      if ((addr & ~32'(4*NR-1)) == BASE) begin
         exp_b_q.push_back(2'b00);
         model[idx] = merge(model[idx], data, strb);
      end else begin
         exp_b_q.push_back(2'b10);
      end
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr);
      logic ar_done, ar_fire;
      logic [33:0] e;
      int idx;
      idx = int'((addr - BASE) >> 2);
      if ((addr & ~32'(4*NR-1)) == BASE) exp_q.push_back({2'b00, model[idx]});
      else                               exp_q.push_back({2'b10, 32'd0});
      axi_araddr = addr; axi_arvalid = 1'b1; ar_done = 1'b0;
      for (int k = 0; k < 50 && !ar_done; k++) begin
         ar_fire = axi_arvalid && axi_arready;
         @(negedge clk);
         if (ar_fire) begin ar_done = 1'b1; axi_arvalid = 1'b0; end
      end
      axi_arvalid = 1'b0;
      chk({tag, "_ar_accept"}, 32'(ar_done), 32'd1);
      for (int k = 0; k < 20 && !axi_rvalid; k++) @(negedge clk);
      chk({tag, "_rvalid"}, 32'(axi_rvalid), 32'd1);
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, axi_rdata, e[31:0]);
      chk({tag, "_rresp"}, 32'(axi_rresp), 32'(e[33:32]));
   endtask

   initial begin
      for (int i = 0; i < NR; i++) model[i] = '0;

      // Reset and idle state
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      chk("rst_awready", 32'(axi_awready), 32'd1);
      chk("rst_wready", 32'(axi_wready), 32'd1);
      chk("rst_arready", 32'(axi_arready), 32'd1);
      chk("rst_bvalid", 32'(axi_bvalid), 32'd0);
      chk("rst_rvalid", 32'(axi_rvalid), 32'd0);
      chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      chk_regs("rst");
      for (int i = 0; i < NR; i++) do_read($sformatf("rst_rd%0d", i), BASE + 32'(4*i));
      @(negedge clk);

      // Full write, AW and W together
      do_write("w1", BASE + 32'h8, 32'hDEAD_BEEF, 4'hF);
      chk_b("w1");
      chk("w1_pulse", 32'(wr_pulse), 32'h0000_0004);
      chk_regs("w1");
      @(negedge clk);
      chk("w1_pulse_off", 32'(wr_pulse), 32'd0);
      chk("w1_bvalid_off", 32'(axi_bvalid), 32'd0);
      do_read("w1_rd", BASE + 32'h8);
      @(negedge clk);

      // W leads AW by 3 cycles with partial strobe
      axi_wdata = 32'h1122_3344; axi_wstrb = 4'b0101; axi_wvalid = 1'b1;
      @(negedge clk);
      axi_wvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("w2_hold_bvalid%0d", k), 32'(axi_bvalid), 32'd0);
         chk($sformatf("w2_hold_wready%0d", k), 32'(axi_wready), 32'd0);
         chk($sformatf("w2_hold_awready%0d", k), 32'(axi_awready), 32'd1);
         chk($sformatf("w2_hold_reg%0d", k), regs_out[64 +: 32], 32'hDEAD_BEEF);
         @(negedge clk);
      end
      axi_awaddr = BASE + 32'h8; axi_awvalid = 1'b1;
      exp_b_q.push_back(2'b00);
      model[2] = merge(model[2], 32'h1122_3344, 4'b0101);
      @(negedge clk);
      axi_awvalid = 1'b0;
      chk_b("w2");
      chk("w2_pulse", 32'(wr_pulse), 32'h0000_0004);
      chk("w2_reg_value", regs_out[64 +: 32], 32'hDE22_BE44);
      chk_regs("w2");
      @(negedge clk);
      do_read("w2_rd", BASE + 32'h8);
      @(negedge clk);

      // Out-of-range address
      do_write("w3", BASE + 32'(4*NR), 32'hFFFF_FFFF, 4'hF);
      chk_b("w3");
      chk("w3_pulse", 32'(wr_pulse), 32'd0);
      chk_regs("w3");
      @(negedge clk);
      do_read("w3_rd", BASE + 32'(4*NR));
      @(negedge clk);

      // Back-pressure on B stalls a queued second write
      axi_bready = 1'b0;
      do_write("w4", BASE + 32'hC, 32'hA5A5_0001, 4'hF);
      chk_b("w4");
      axi_awaddr = BASE + 32'h10; axi_wdata = 32'h0000_BEEF; axi_wstrb = 4'hF;
      axi_awvalid = 1'b1; axi_wvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("w4_stall_bvalid%0d", k), 32'(axi_bvalid), 32'd1);
         chk($sformatf("w4_stall_awready%0d", k), 32'(axi_awready), 32'd0);
         chk($sformatf("w4_stall_wready%0d", k), 32'(axi_wready), 32'd0);
         chk($sformatf("w4_stall_reg4_%0d", k), regs_out[128 +: 32], 32'd0);
      end
      axi_bready = 1'b1;
      @(negedge clk);
      chk("w5_bvalid_cleared", 32'(axi_bvalid), 32'd0);
      chk("w5_awready", 32'(axi_awready), 32'd1);
      chk("w5_reg4_pre", regs_out[128 +: 32], 32'd0);
      exp_b_q.push_back(2'b00);
      model[4] = 32'h0000_BEEF;
      @(negedge clk);
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      chk_b("w5");
      chk("w5_pulse", 32'(wr_pulse), 32'h0000_0010);
      chk_regs("w5");
      @(negedge clk);

      // Reset during a held AW and a pending read response
      axi_rready = 1'b0;
      axi_awaddr = BASE + 32'h14; axi_awvalid = 1'b1;
      axi_araddr = BASE + 32'hC;  axi_arvalid = 1'b1;
      @(negedge clk);
      axi_awvalid = 1'b0; axi_arvalid = 1'b0;
      chk("r6_rvalid_pend", 32'(axi_rvalid), 32'd1);
      chk("r6_awready_held", 32'(axi_awready), 32'd0);
      resetn = 1'b0;
      exp_q.delete(); exp_b_q.delete();
      for (int i = 0; i < NR; i++) model[i] = '0;
      @(negedge clk);
      resetn = 1'b1;
      chk("r6_rvalid", 32'(axi_rvalid), 32'd0);
      chk("r6_rdata", axi_rdata, 32'd0);
      chk("r6_rresp", 32'(axi_rresp), 32'd0);
      chk("r6_bvalid", 32'(axi_bvalid), 32'd0);
      chk("r6_bresp", 32'(axi_bresp), 32'd0);
      chk("r6_awready", 32'(axi_awready), 32'd1);
      chk("r6_wready", 32'(axi_wready), 32'd1);
      chk("r6_arready", 32'(axi_arready), 32'd1);
      chk("r6_pulse", 32'(wr_pulse), 32'd0);
      chk_regs("r6");
      axi_rready = 1'b1;
      axi_wdata = 32'h5555_AAAA; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      @(negedge clk);
      axi_wvalid = 1'b0;
      repeat (2) begin
         chk("r6_no_commit_bvalid", 32'(axi_bvalid), 32'd0);
         chk("r6_no_commit_reg5", regs_out[160 +: 32], 32'd0);
         @(negedge clk);
      end
      axi_awaddr = BASE + 32'h18; axi_awvalid = 1'b1;
      exp_b_q.push_back(2'b00);
      model[6] = 32'h5555_AAAA;
      @(negedge clk);
      axi_awvalid = 1'b0;
      chk_b("r6_w");
      chk("r6_w_pulse", 32'(wr_pulse), 32'h0000_0040);
      chk_regs("r6_w");
      @(negedge clk);
      do_read("r6_rd5", BASE + 32'h14);
      @(negedge clk);
      do_read("r6_rd6", BASE + 32'h18);
      @(negedge clk);

      chk("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("end_exp_b_q_empty", 32'(exp_b_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axiregbank.md
# axiregbank

AXI4-lite slave (responder) exposing a bank of 32-bit read/write control registers to an AXI4-lite master, e.g. the video timing/config registers written by the CPU or by the bench's AXI command player. It accepts the address and data channels independently, applies byte strobes, and returns write and read responses. It also presents all register contents, plus per-register write strobes, to the fabric.

## Interface
- NUM_REGS, 16: number of 32-bit registers, 1..256.
- BASE_ADDR, 32'h0000_0000: byte address of register 0; aligned to 4*2^clog2(NUM_REGS).
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- axi_awvalid/axi_awready  in/out  1  write address handshake.
- axi_awaddr  in  32  write byte address; axi_awprot in 3, ignored.
- axi_wvalid/axi_wready  in/out  1  write data handshake.
- axi_wdata  in  32; axi_wstrb  in  4  byte-lane enables.
- axi_bvalid/axi_bready  out/in  1; axi_bresp  out  2.
- axi_arvalid/axi_arready  in/out  1; axi_araddr  in  32; axi_arprot in 3, ignored.
- axi_rvalid/axi_rready  out/in  1; axi_rdata  out  32; axi_rresp  out  2.
- regs_out  out  32*NUM_REGS  register i at [32*i +: 32].
- wr_pulse  out  NUM_REGS  bit i high one cycle after register i is written with any strobe set.

## Operation
- Decode: hit when (addr & ~(4*2^clog2(NUM_REGS)-1)) == BASE_ADDR and index addr[2 +: clog2(NUM_REGS)] < NUM_REGS; addr[1:0] ignored.
- Write path holds aw_held/aw_addr and w_held/w_data/w_strb.
- axi_awready = !aw_held && !axi_bvalid; axi_wready = !w_held && !axi_bvalid.
- Commit edge: first edge at which both AW and W are available (held or handshaking that edge) and axi_bvalid is low. On commit: lanes with strobe set updated on hit; miss discards data; held flags cleared; axi_bvalid set; axi_bresp = OKAY (2'b00) on hit, SLVERR (2'b10) on miss; wr_pulse[idx] set for exactly one cycle if hit and strobe != 0.
- axi_bvalid clears on edge with axi_bready high.
- Read: axi_arready = !axi_rvalid. On AR handshake, axi_rdata = register (0 on miss), axi_rresp = OKAY/SLVERR, axi_rvalid set; clears on edge with axi_rready. rdata/rresp stable while rvalid high.
- Read and write channels fully independent; a read of a register committed on the same edge returns the pre-write value.

## Timing
- Reset (resetn low at posedge): all registers 0, regs_out 0, wr_pulse 0, held flags 0, axi_bvalid/axi_rvalid 0, axi_bresp/axi_rresp 0, axi_rdata 0; readies then evaluate to 1.
- Reset mid-transaction aborts it: held AW/W discarded, pending B/R dropped, no register change.
- AW and W same cycle: commit on that edge, bvalid high next cycle (write latency 1).
- AW before W (or vice versa): held; commit on the edge the other handshakes.
- bready held low: bvalid remains, both write readies low, no further commit.
- Read latency 1: rvalid high the cycle after AR handshake; max one read per 2 cycles with rready tied high.
- regs_out reflects a write the cycle after commit, together with wr_pulse and bvalid.

## Structure
- Shared package/include: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, clog2 function.
- Single module; decode as a local function, no sub-module.

## Test plan
- Reset then read all NUM_REGS -> rdata 0, rresp OKAY; readies high after reset.
- w32 BASE+0x8 = 0xDEADBEEF with AW/W same cycle, bready high -> bvalid next cycle, bresp 0, wr_pulse[2] one cycle, regs_out[95:64] = 0xDEADBEEF, readback matches.
- W 3 cycles before AW, wstrb 4'b0101, data 0x11223344 over 0xDEADBEEF -> no commit until AW; result 0xDE22BE44.
- Write to BASE+4*NUM_REGS and read it -> bresp/rresp 2'b10, rdata 0, no register or wr_pulse change.
- bready low 5 cycles after write -> bvalid stays high, awready/wready low, second queued write commits only after B handshake.
- Assert resetn low while AW held and rvalid pending -> all outputs return to reset values, held write never lands.
